// File: rtl/tile_map_scheduler.sv
// Tile-map RAM arbiter: video prefetch owns fixed slots, queued CPU tile writes drain in free cycles.
// Optional macro TILE_MAP_VBLANK_COMMIT_EN gates CPU drains to vertical blank (vcount >= 480).
module tile_map_scheduler #(
  parameter int MAP_W      = 40,
  parameter int MAP_H      = 30,
  parameter int CODE_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              cpu_valid,
  input  logic [5:0]        cpu_x,
  input  logic [4:0]        cpu_y,
  input  logic [CODE_W-1:0] cpu_code,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CODE_W-1:0] ram_wdata,
  input  logic [CODE_W-1:0] ram_rdata,
  output logic [CODE_W-1:0] tile_code,
  output logic              tile_valid,
  output logic [7:0]        drop_count
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [5:0]      MAP_W_C = 6'(MAP_W);
  localparam logic [5:0]      MAP_H_C = 6'(MAP_H);
  localparam logic [PTR_W:0]  PTR_ONE = (PTR_W+1)'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CODE_W-1:0] code;
  } wr_entry_t;

  // Row-major map address; 40 columns decomposes into 32 + 8.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] row, input logic [5:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 5) + (r << 3) + ADDR_W'(col);
  endfunction

  // Prefetch target: the tile that follows the one currently being scanned.
  logic              slot_s, slot_s1, last_col;
  logic [5:0]        col, nc, nr;
  logic              fetch_in_map;
  logic [ADDR_W-1:0] fetch_addr;

  assign col          = hcount[10:5];
  assign slot_s       = (hcount[4:0] == 5'd0);
  assign slot_s1      = (hcount[4:0] == 5'd1);
  assign last_col     = (col == 6'd49);
  assign nc           = last_col ? 6'd0 : col + 6'd1;
  assign nr           = !last_col ? vcount[9:4] :
                        (vcount == 10'd524) ? 6'd0 : 6'((vcount + 10'd1) >> 4);
  assign fetch_in_map = (nc < MAP_W_C) && (nr < MAP_H_C);
  assign fetch_addr   = tile_addr(nr, nc);

  // CPU write queue
  wr_entry_t      fifo_mem [FIFO_DEPTH];
  wr_entry_t      head;
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full, push, in_range, pop, drain_gate;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cpu_ready  = !fifo_full;
  assign push       = cpu_valid && cpu_ready;
  assign in_range   = (cpu_x < MAP_W_C) && ({1'b0, cpu_y} < MAP_H_C);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

`ifdef TILE_MAP_VBLANK_COMMIT_EN
  assign drain_gate = (vcount >= 10'd480);
`else
  assign drain_gate = 1'b1;
`endif

  assign pop = !fifo_empty && !slot_s && !slot_s1 && drain_gate;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (push && in_range) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)              rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // NOTE: queue storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push && in_range)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= '{addr: tile_addr({1'b0, cpu_y}, cpu_x), code: cpu_code};
  end

  // Prefetch pipeline: address in S, capture in S+1, publish on the last clock of the tile.
  logic              fetch_pending;
  logic [CODE_W-1:0] next_code;
  logic              next_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pending <= 1'b0;
      next_code     <= '0;
      next_valid    <= 1'b0;
      tile_code     <= '0;
      tile_valid    <= 1'b0;
    end else begin
      fetch_pending <= slot_s && fetch_in_map;
      if (slot_s && !fetch_in_map) begin
        next_code  <= '0;
        next_valid <= 1'b0;
      end else if (slot_s1 && fetch_pending) begin
        next_code  <= ram_rdata;
        next_valid <= 1'b1;
      end
      if (hcount[4:0] == 5'd31) begin
        tile_code  <= next_code;
        tile_valid <= next_valid;
      end
    end
  end

  // NOTE: every output gets a default before the priority chain, so no latch can be inferred.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (slot_s && fetch_in_map) begin
      ram_addr = fetch_addr;
    end else if (pop) begin
      ram_we    = 1'b1;
      ram_addr  = head.addr;
      ram_wdata = head.code;
    end
  end

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed self-checking bench for tile_map_scheduler with a behavioural single-port RAM.
// Build with TILE_MAP_VBLANK_COMMIT_EN defined to exercise the vblank-gated drain.
module tb_tile_map_scheduler;

  localparam int CODE_W = 4;
  localparam int ADDR_W = 11;
`ifdef TILE_MAP_VBLANK_COMMIT_EN
  localparam logic [9:0] DRAIN_V = 10'd490;
`else
  localparam logic [9:0] DRAIN_V = 10'd200;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic              cpu_valid;
  logic [5:0]        cpu_x;
  logic [4:0]        cpu_y;
  logic [CODE_W-1:0] cpu_code;
  logic              cpu_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [CODE_W-1:0] ram_wdata;
  logic [CODE_W-1:0] ram_rdata;
  logic [CODE_W-1:0] tile_code;
  logic              tile_valid;
  logic [7:0]        drop_count;

  int errors = 0;
  int checks = 0;

  logic [CODE_W-1:0] mem [2048];

  tile_map_scheduler dut (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .cpu_valid(cpu_valid), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_code(cpu_code),
    .cpu_ready(cpu_ready), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tile_code(tile_code), .tile_valid(tile_valid),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Drive counters just after the edge, return mid-cycle for sampling and CPU stimulus.
  task automatic cyc(input logic [10:0] h, input logic [9:0] v);
    @(posedge clk);
    #1;
    hcount = h;
    vcount = v;
    #4;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", cpu_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", ram_we); end
    checks++; if (ram_addr !== 11'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", ram_addr); end
    checks++; if (ram_wdata !== 4'd0) begin errors++; $display("FAIL rst_wdata: got %0d want 0", ram_wdata); end
    checks++; if (tile_code !== 4'd0) begin errors++; $display("FAIL rst_code: got %0d want 0", tile_code); end
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", tile_valid); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
    cyc(11'd10, 10'd0);
    reset_n = 1'b1;
  endtask

  task automatic test_single_write;
    cyc(11'd10, 10'd0);
    cpu_valid = 1'b1; cpu_x = 6'd5; cpu_y = 5'd3; cpu_code = 4'd7;
    cyc(11'd11, 10'd0);
    cpu_valid = 1'b0;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL single_we: got %0b want 1", ram_we); end
    checks++; if (ram_addr !== 11'd125) begin errors++; $display("FAIL single_addr: got %0d want 125", ram_addr); end
    checks++; if (ram_wdata !== 4'd7) begin errors++; $display("FAIL single_wdata: got %0d want 7", ram_wdata); end
    cyc(11'd12, 10'd0);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b want 0", ram_we); end
  endtask

  task automatic test_slot_protection;
    // Last column prefetches column 0 of the next line (vcount 16 -> row 1).
    cyc(11'd1568, 10'd15);
    checks++; if (ram_addr !== 11'd40) begin errors++; $display("FAIL wrap_prefetch_addr: got %0d want 40", ram_addr); end
    cyc(11'd1599, 10'd15);
    cpu_valid = 1'b1; cpu_x = 6'd2; cpu_y = 5'd1; cpu_code = 4'd3;
    cyc(11'd0, 10'd16);
    cpu_valid = 1'b0;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL slot_s_we: got %0b want 0", ram_we); end
    checks++; if (ram_addr !== 11'd41) begin errors++; $display("FAIL slot_s_addr: got %0d want 41", ram_addr); end
    cyc(11'd1, 10'd16);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL slot_s1_we: got %0b want 0", ram_we); end
    cyc(11'd2, 10'd16);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL slot_drain_we: got %0b want 1", ram_we); end
    checks++; if (ram_addr !== 11'd42) begin errors++; $display("FAIL slot_drain_addr: got %0d want 42", ram_addr); end
    checks++; if (ram_wdata !== 4'd3) begin errors++; $display("FAIL slot_drain_wdata: got %0d want 3", ram_wdata); end
  endtask

  task automatic test_fetch_alignment;
    logic [CODE_W-1:0] exp_code;
    logic              exp_valid;
    for (int h = 32; h < 1600; h++) begin
      cyc(11'(h), 10'd40);
      if (h >= 64) begin
        exp_valid = (h < 1280);
        exp_code  = (h >= 128 && h <= 159) ? 4'd9 : 4'd0;
        checks++; if (tile_valid !== exp_valid) begin errors++; $display("FAIL fetch_valid h=%0d: got %0b want %0b", h, tile_valid, exp_valid); end
        checks++; if (tile_code !== exp_code) begin errors++; $display("FAIL fetch_code h=%0d: got %0d want %0d", h, tile_code, exp_code); end
      end
    end
  endtask

  task automatic test_drop;
    cyc(11'd10, DRAIN_V);
    cpu_valid = 1'b1; cpu_x = 6'd40; cpu_y = 5'd0; cpu_code = 4'd6;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b want 1", cpu_ready); end
    cyc(11'd11, DRAIN_V);
    cpu_x = 6'd0; cpu_y = 5'd30;
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_x: got %0d want 1", drop_count); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL drop_x_we: got %0b want 0", ram_we); end
    cyc(11'd12, DRAIN_V);
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL drop_y: got %0d want 2", drop_count); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL drop_y_we: got %0b want 0", ram_we); end
    cpu_x = 6'd63; cpu_y = 5'd31;
    for (int i = 0; i < 252; i++) cyc(11'd12, DRAIN_V);
    cyc(11'd12, DRAIN_V);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_reach_255: got %0d want 255", drop_count); end
    cyc(11'd12, DRAIN_V);
    cpu_valid = 1'b0;
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d want 255", drop_count); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL drop_no_write: got %0b want 0", ram_we); end
  endtask

  task automatic test_backpressure;
    // Holding hcount in S+1 keeps the drain blocked.
    for (int i = 0; i < 4; i++) begin
      cyc(11'd1, DRAIN_V);
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %0b want 1", i, cpu_ready); end
      cpu_valid = 1'b1; cpu_x = 6'(10 + i); cpu_y = 5'd20; cpu_code = 4'(i + 1);
    end
    cyc(11'd1, DRAIN_V);
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %0b want 0", cpu_ready); end
    cpu_x = 6'd14; cpu_code = 4'd5;
    cyc(11'd1, DRAIN_V);
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL bp_held: got %0b want 0", cpu_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL bp_blocked_we: got %0b want 0", ram_we); end
    for (int i = 0; i < 5; i++) begin
      cyc(11'(10 + i), DRAIN_V);
      if (i == 2) cpu_valid = 1'b0;
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL bp_drain_we_%0d: got %0b want 1", i, ram_we); end
      checks++; if (ram_addr !== 11'(810 + i)) begin errors++; $display("FAIL bp_drain_addr_%0d: got %0d want %0d", i, ram_addr, 810 + i); end
      checks++; if (ram_wdata !== 4'(i + 1)) begin errors++; $display("FAIL bp_drain_wdata_%0d: got %0d want %0d", i, ram_wdata, i + 1); end
      if (i == 0) begin
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_first_pop: got %0b want 0", cpu_ready); end
      end
      if (i == 1) begin
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen: got %0b want 1", cpu_ready); end
      end
    end
    cyc(11'd15, DRAIN_V);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL bp_empty_we: got %0b want 0", ram_we); end
  endtask

`ifdef TILE_MAP_VBLANK_COMMIT_EN
  task automatic test_vblank_commit;
    cyc(11'd10, 10'd100);
    cpu_valid = 1'b1; cpu_x = 6'd1; cpu_y = 5'd1; cpu_code = 4'd1;
    cyc(11'd11, 10'd100);
    cpu_x = 6'd2; cpu_code = 4'd2;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL vb_active_we0: got %0b want 0", ram_we); end
    cyc(11'd12, 10'd100);
    cpu_valid = 1'b0;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL vb_active_we1: got %0b want 0", ram_we); end
    cyc(11'd13, 10'd479);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL vb_active_we2: got %0b want 0", ram_we); end
    cyc(11'd10, 10'd480);
    checks++; if (ram_we !== 1'b1 || ram_addr !== 11'd41 || ram_wdata !== 4'd1) begin errors++; $display("FAIL vb_drain0: got we=%0b addr=%0d data=%0d want 1/41/1", ram_we, ram_addr, ram_wdata); end
    cyc(11'd11, 10'd480);
    checks++; if (ram_we !== 1'b1 || ram_addr !== 11'd42 || ram_wdata !== 4'd2) begin errors++; $display("FAIL vb_drain1: got we=%0b addr=%0d data=%0d want 1/42/2", ram_we, ram_addr, ram_wdata); end
    cyc(11'd12, 10'd480);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL vb_done_we: got %0b want 0", ram_we); end
  endtask
`endif

  task automatic test_reset_mid;
    // Load tile_code=9 (row 2, col 4) so the reset has visible state to clear.
    for (int h = 96; h < 128; h++) cyc(11'(h), 10'd40);
    cyc(11'd1, 10'd40);
    checks++; if (tile_code !== 4'd9) begin errors++; $display("FAIL mid_pre_code: got %0d want 9", tile_code); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc(11'd1, 10'd40);
      cpu_valid = 1'b1; cpu_x = 6'(i); cpu_y = 5'd0; cpu_code = 4'(i + 1);
    end
    cyc(11'd1, 10'd40);
    cpu_valid = 1'b0;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL mid_pre_ready: got %0b want 1", cpu_ready); end
    reset_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %0b want 0", ram_we); end
    checks++; if (tile_code !== 4'd0) begin errors++; $display("FAIL mid_rst_code: got %0d want 0", tile_code); end
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", tile_valid); end
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b want 1", cpu_ready); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_rst_drop: got %0d want 0", drop_count); end
    cyc(11'd10, DRAIN_V);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(11'(11 + i), DRAIN_V);
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_stale_we_%0d: got %0b want 0", i, ram_we); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[84] = 4'd9;
    reset_n   = 1'b0;
    hcount    = 11'd10;
    vcount    = 10'd0;
    cpu_valid = 1'b0;
    cpu_x     = '0;
    cpu_y     = '0;
    cpu_code  = '0;

    test_reset();
`ifdef TILE_MAP_VBLANK_COMMIT_EN
    test_vblank_commit();
`else
    test_single_write();
    test_slot_protection();
`endif
    test_fetch_alignment();
    test_drop();
    test_backpressure();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_map_scheduler.md
Name: tile_map_scheduler

Overview:
- Owns the single-port tile-map RAM behind the sprite renderer. The map is 40x30 tiles of 16x16 pixels, indexed by hcount[10:5] and vcount[9:4].
- Shares the RAM between two requesters:
  - the video fetch, which has absolute priority in fixed slots;
  - CPU tile-update writes, queued in a small FIFO and drained in free cycles.
- Delivers a registered per-tile code to the pixel mux, aligned to tile boundaries.

Parameters:
- MAP_W, 40, tile columns.
- MAP_H, 30, tile rows.
- CODE_W, 4, tile code width (index into sprite ROM set).
- FIFO_DEPTH, 4, CPU write queue entries (power of 2).
- ADDR_W, 11, RAM address width (covers MAP_W*MAP_H = 1200).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- hcount  in  11  horizontal counter, 0..1599 (from vga_counters).
- vcount  in  10  vertical counter, 0..524 (from vga_counters).
- cpu_valid  in  1  tile write request.
- cpu_x  in  6  tile column.
- cpu_y  in  5  tile row.
- cpu_code  in  CODE_W  tile code to store.
- cpu_ready  out  1  queue can accept (=!full).
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  CODE_W  RAM write data.
- ram_rdata  in  CODE_W  RAM read data, 1-cycle synchronous latency.
- tile_code  out  CODE_W  code for the tile currently being scanned.
- tile_valid  out  1  current tile lies inside the map.
- drop_count  out  8  saturating count of rejected out-of-range writes.

Behaviour:
- Reset: the clock is clk; reset is asynchronous and active-low on reset_n.
  - FIFO empty, so cpu_ready=1.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - tile_code=0, tile_valid=0, drop_count=0.
  - Internal next_code/next_valid are cleared.
  - Reset mid-drain discards all queued writes; a write in progress is not completed.
- Fetch slot (video has priority):
  - Cycle S is hcount[4:0]==0. Cycle S+1 is reserved so read data stays stable; no write is issued in S or S+1.
  - Target column: nc = hcount[10:5]+1, except nc=0 when hcount[10:5]==49.
  - Target row: nr = vcount[9:4]. When nc==0, nr = the row of the next line, with vcount 524 wrapping to 0.
  - In S: ram_addr = nr*40+nc, computed as (nr<<5)+(nr<<3)+nc; ram_we=0. This happens only if nc<MAP_W and nr<MAP_H; otherwise no read and next_valid=0.
  - In S+1: next_code <= ram_rdata and next_valid <= 1.
  - In the cycle where hcount[4:0]==31: tile_code <= next_code and tile_valid <= next_valid.
  - Net effect: tile_code is stable for all 32 clocks of the tile it describes. When tile_valid=0, tile_code=0.
- CPU side:
  - Push when cpu_valid && cpu_ready.
  - Range check at push: if cpu_x>=MAP_W or cpu_y>=MAP_H, the entry is not queued and drop_count increments, saturating at 255.
  - When full, cpu_ready=0; requests held with cpu_valid are not lost and wait.
- Drain:
  - Allowed in any cycle that is not S or S+1 and where the FIFO is non-empty.
  - Pops one entry per cycle: ram_we=1, ram_addr=y*40+x, ram_wdata=code.
  - In non-drain cycles ram_we=0.
- Latency: a push accepted in cycle T gives an earliest ram_we at T+1, or later if T+1 falls in a fetch slot.
- Simultaneous push and pop: allowed when not full; the count is unchanged.
- Ordering and read-after-write:
  - Writes drain in FIFO order.
  - A write to the tile being prefetched that lands before S is visible; one landing after S appears next frame.
- Arithmetic: FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Address math is done at ADDR_W without overflow (max 1199).

Optional Feature:
- Macro: TILE_MAP_VBLANK_COMMIT_EN.
- Defined: drain is additionally gated to vertical blank (vcount>=480), giving tear-free map updates. During active video the FIFO only fills, and cpu_ready drops once it is full.
- Undefined: drain proceeds in any non-slot cycle, as described in Behaviour.

Test Plan:
- Reset: assert reset_n=0 mid-line with 3 queued entries -> ram_we=0, tile_code=0, cpu_ready=1, drop_count=0 immediately; after release the FIFO is empty and no stale write is issued.
- Single write: push (x=5,y=3,code=7) at hcount=10 -> ram_we=1 next cycle with ram_addr=125, ram_wdata=7.
- Slot protection: push at hcount=1599 so the drain would land at hcount=0/1 -> ram_we stays 0 at hcount 0 and 1 and pulses at hcount=2. At hcount=0 ram_addr equals the prefetch address.
- Fetch alignment: RAM holds code 9 at (row 2, col 4); scan vcount=40 -> tile_code=9 and tile_valid=1 exactly for hcount 128..159. At hcount 1280..1599 tile_valid=0 and tile_code=0.
- Backpressure and drop: 5 back-to-back pushes during a blocked drain -> cpu_ready=0 after 4 accepted and the 5th is held; push x=40 -> drop_count=1 and no RAM write.
- Macro on: push at vcount=100 -> no ram_we until vcount=480; then all entries drain in order.
